// File: rtl/m_uart_loader_pkg.sv
// rtl/m_uart_loader_pkg.sv - shared state encodings and build defaults for the UART program loader
package m_uart_loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DONE,
    S_ERR
  } ldr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/m_uart_rx.sv
// rtl/m_uart_rx.sv - 8N1 UART receiver with 2-flop synchroniser and mid-bit sampling
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       w_rxd,
  output logic [7:0] r_byte,
  output logic       r_valid,
  output logic       r_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic          meta_q, sync_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= w_rxd;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync_q && prev_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid-start means the edge was a glitch.
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign r_byte  = shift_q;
  assign r_valid = valid_q;
  assign r_ferr  = ferr_q;

endmodule

// File: rtl/m_uart_loader.sv
// rtl/m_uart_loader.sv - header/word FSM that writes UART-received big-endian words into instruction memory
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_waddr,
  output logic [31:0]       r_wdata,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_rxd  (w_rxd),
    .r_byte (rx_byte),
    .r_valid(rx_valid),
    .r_ferr (rx_ferr)
  );

  ldr_state_e        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= S_HDR0;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_HDR0: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          n_d[15:8] = rx_byte;
          state_d   = S_HDR1;
        end
      end
      S_HDR1: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          n_d    = {n_q[15:8], rx_byte};
          idx_d  = '0;
          bcnt_d = '0;
          if (n_d == 16'd0)                     state_d = S_DONE;
          else if ({16'd0, n_d} > MAX_WORDS)    state_d = S_ERR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = {asm_q, rx_byte};
            idx_d   = idx_q + 1'b1;
            bcnt_d  = '0;
            // Index is one bit wider than the address so N = 2^ADDR_W terminates.
            if (32'(idx_q) + 32'd1 == 32'(n_q)) state_d = S_DONE;
          end else begin
            asm_d  = {asm_q[15:0], rx_byte};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_ERR;
    endcase
  end

  assign r_we    = we_q;
  assign r_waddr = waddr_q;
  assign r_wdata = wdata_q;
  assign r_busy  = (state_q != S_DONE);
  assign r_done  = (state_q == S_DONE);
  assign r_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_m_uart_loader.sv
// tb/tb_m_uart_loader.sv - scoreboard bench for the UART program loader
module tb_m_uart_loader;

  localparam int CLKS = 8;
  localparam int AW   = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            last;
  } wr_t;

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b0;
  logic          w_rxd = 1'b1;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;
  logic          r_busy, r_done, r_err;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  m_uart_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(AW)) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_rxd  (w_rxd),
    .r_we   (r_we),
    .r_waddr(r_waddr),
    .r_wdata(r_wdata),
    .r_busy (r_busy),
    .r_done (r_done),
    .r_err  (r_err)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk) begin
    if (w_rst_n && r_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h required no write", r_waddr, r_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (r_waddr !== e.addr || r_wdata !== e.data) begin
          errors++;
          $display("FAIL write_data got %0h/%08h required %0h/%08h", r_waddr, r_wdata, e.addr, e.data);
        end
        checks++;
        if (r_busy !== !e.last || r_done !== e.last) begin
          errors++;
          $display("FAIL busy_at_write got busy=%b done=%b required busy=%b done=%b",
                   r_busy, r_done, !e.last, e.last);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge w_clk);
    w_rxd = 1'b0;
    repeat (CLKS) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (CLKS) @(negedge w_clk);
    end
    w_rxd = stop;
    repeat (CLKS) @(negedge w_clk);
    w_rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic apply_reset();
    w_rxd = 1'b1;
    @(negedge w_clk);
    w_rst_n = 1'b0;
    repeat (3) @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (3) @(negedge w_clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({r_we, r_waddr, r_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_write_port got we=%b addr=%0h data=%08h required all zero", r_we, r_waddr, r_wdata);
    end
    checks++;
    if ({r_busy, r_done, r_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_status got busy/done/err=%b required 100", {r_busy, r_done, r_err});
    end
  endtask

  task automatic test_two_words();
    apply_reset();
    exp_q.push_back('{addr: 4'h0, data: 32'h24000020, last: 1'b0});
    exp_q.push_back('{addr: 4'h1, data: 32'h20081000, last: 1'b1});
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h24000020);
    send_word(32'h20081000);
    for (int i = 0; i < 20 * CLKS && exp_q.size() != 0; i++) @(negedge w_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL two_words_pending got %0d writes outstanding required 0", exp_q.size());
    end
    checks++;
    if ({r_busy, r_done, r_err} !== 3'b010) begin
      errors++;
      $display("FAIL two_words_status got busy/done/err=%b required 010", {r_busy, r_done, r_err});
    end
  endtask

  task automatic test_zero_header();
    bit seen = 0;
    apply_reset();
    send_byte(8'h00, 1'b1);
    fork
      send_byte(8'h00, 1'b1);
    join_none
    for (int i = 0; i < 14 * CLKS; i++) begin
      @(negedge w_clk);
      if (dut.rx_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL zero_hdr_valid got no byte_valid required one");
    end
    checks++;
    if (r_busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_hdr_busy_early got %b required 1", r_busy);
    end
    @(negedge w_clk);
    checks++;
    if ({r_busy, r_done, r_err} !== 3'b010) begin
      errors++;
      $display("FAIL zero_hdr_status got busy/done/err=%b required 010", {r_busy, r_done, r_err});
    end
    repeat (2 * CLKS) @(negedge w_clk);
  endtask

  task automatic test_frame_err();
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (2) @(negedge w_clk);
    checks++;
    if ({r_busy, r_done, r_err} !== 3'b101) begin
      errors++;
      $display("FAIL frame_err_status got busy/done/err=%b required 101", {r_busy, r_done, r_err});
    end
    send_byte(8'h44, 1'b1);
    repeat (2 * CLKS) @(negedge w_clk);
    checks++;
    if ({r_busy, r_done, r_err, r_we} !== 4'b1010) begin
      errors++;
      $display("FAIL frame_err_sticky got busy/done/err/we=%b required 1010", {r_busy, r_done, r_err, r_we});
    end
  endtask

  task automatic test_oversize();
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (2) @(negedge w_clk);
    checks++;
    if ({r_busy, r_done, r_err} !== 3'b101) begin
      errors++;
      $display("FAIL oversize_status got busy/done/err=%b required 101", {r_busy, r_done, r_err});
    end
  endtask

  task automatic test_full_memory();
    logic [31:0] w;
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      exp_q.push_back('{addr: AW'(i), data: w, last: (i == 15)});
      send_word(w);
    end
    for (int i = 0; i < 20 * CLKS && exp_q.size() != 0; i++) @(negedge w_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_pending got %0d writes outstanding required 0", exp_q.size());
    end
    checks++;
    if (r_waddr !== 4'hF || r_wdata !== w) begin
      errors++;
      $display("FAIL full_hold got %0h/%08h required f/%08h", r_waddr, r_wdata, w);
    end
    checks++;
    if ({r_busy, r_done, r_err} !== 3'b010) begin
      errors++;
      $display("FAIL full_status got busy/done/err=%b required 010", {r_busy, r_done, r_err});
    end
    send_word(32'hDEADBEEF);
  endtask

  task automatic test_glitch();
    apply_reset();
    @(negedge w_clk);
    w_rxd = 1'b0;
    repeat (2) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (3 * CLKS) @(negedge w_clk);
    exp_q.push_back('{addr: 4'h0, data: 32'hCAFE0123, last: 1'b1});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(32'hCAFE0123);
    for (int i = 0; i < 20 * CLKS && exp_q.size() != 0; i++) @(negedge w_clk);
    checks++;
    if (exp_q.size() != 0 || r_done !== 1'b1) begin
      errors++;
      $display("FAIL glitch_recover got pending=%0d done=%b required 0/1", exp_q.size(), r_done);
    end
  endtask

  task automatic test_reset_midword();
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    apply_reset();
    checks++;
    if ({r_we, r_waddr, r_wdata, r_busy, r_done, r_err} !== {1'b0, 4'h0, 32'h0, 3'b100}) begin
      errors++;
      $display("FAIL midword_reset got we=%b addr=%0h data=%08h bde=%b required 0/0/0/100",
               r_we, r_waddr, r_wdata, {r_busy, r_done, r_err});
    end
    exp_q.push_back('{addr: 4'h0, data: 32'h01020304, last: 1'b1});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(32'h01020304);
    for (int i = 0; i < 20 * CLKS && exp_q.size() != 0; i++) @(negedge w_clk);
    checks++;
    if (exp_q.size() != 0 || r_wdata !== 32'h01020304) begin
      errors++;
      $display("FAIL midword_reload got pending=%0d data=%08h required 0/01020304", exp_q.size(), r_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_header();
    test_frame_err();
    test_oversize();
    test_full_memory();
    test_glitch();
    test_reset_midword();
    repeat (4) @(negedge w_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_uart_loader.md
# m_uart_loader

Serial program loader that fills the processor's instruction memory over a UART line before execution starts. It receives 8N1 bytes and reads a 2-byte word-count header. It then assembles big-endian 32-bit words and issues one write per word into the instruction-memory write port (`w_we`/`w_addr`/`w_din`). While loading, it holds the processor in reset through `r_busy`; `r_busy` drops only after the last word is written.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `ADDR_W`, default 12: instruction-memory word-address width (4096 words).
- `w_clk`  in  1: system clock; all logic on its rising edge.
- `w_rst_n`  in  1: reset, asynchronous, active-low.
- `w_rxd`  in  1: UART receive line, idle high, asynchronous to `w_clk`.
- `r_we`  out  1: instruction-memory write strobe, one-cycle pulse per word.
- `r_waddr`  out  ADDR_W: word address for the write.
- `r_wdata`  out  32: word data for the write.
- `r_busy`  out  1: high until loading completes; OR into the processor reset.
- `r_done`  out  1: sticky, set when all N words are written.
- `r_err`  out  1: sticky, set on framing error or oversize header.

## Operation
- Reset values: `r_we`=0, `r_waddr`=0, `r_wdata`=0, `r_busy`=1, `r_done`=0, `r_err`=0. The FSM is in HDR0 and the receiver is idle.
- The receiver synchronises `w_rxd` through 2 flip-flops before use.
- The receiver is idle while the line is high. A high→low transition on the synchronised line starts a count of CLKS_PER_BIT/2 (integer division).
  - If the line is high at mid-start, the event is a glitch and the receiver returns to idle.
  - Otherwise it samples 8 data bits, LSB first, every CLKS_PER_BIT cycles, then samples the stop bit.
- Stop bit = 1: the receiver pulses `byte_valid` for 1 cycle with the byte and returns to idle immediately, so back-to-back bytes are accepted.
- Stop bit = 0: the byte is dropped and `frame_err` pulses for 1 cycle.
- Loader FSM states:
  - HDR0: a byte becomes N[15:8]; go to HDR1.
  - HDR1: a byte becomes N[7:0].
    - N=0 → DONE.
    - N > 2^ADDR_W → ERR.
    - Otherwise → DATA, with word index=0 and byte count=0.
  - DATA: each byte shifts into a 32-bit assembler, first byte = bits [31:24]. On the 4th byte of a word:
    - `r_wdata` takes the assembled word and `r_waddr` takes the index; `r_we` pulses.
    - The index increments. When index+1 == N → DONE.
  - DONE: `r_busy`=0 and `r_done`=1. Further bytes are ignored.
  - ERR: `r_err`=1 and `r_busy` stays 1. Further bytes are ignored; only reset exits this state.
- `frame_err` in any state other than DONE or ERR sends the FSM to ERR.
- The word index is ADDR_W+1 bits wide; only the low ADDR_W bits drive `r_waddr`. N = 2^ADDR_W is legal and fills the memory exactly.
- `r_waddr` and `r_wdata` hold their last values between writes.
- Asserting `w_rst_n` low mid-frame or mid-word discards all partial state. Words already written stay in the memory; the loader does not clear it.

## Timing
- Byte latency: `byte_valid` asserts 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start edge, ±1 cycle.
- `r_we` asserts on the cycle after the `byte_valid` of the word's 4th byte and stays high for exactly 1 cycle. `r_waddr` and `r_wdata` are valid in that same cycle.
- `r_busy` falls, and `r_done` rises, on the same cycle as the final `r_we` pulse.
- On N=0, `r_busy` falls 1 cycle after the second header byte's `byte_valid`.
- `r_err` rises 1 cycle after `frame_err`, or 1 cycle after the HDR1 byte when the header is oversize.
- No write ever coincides with `r_busy`=0 before the last word.

## Structure
- Shared package/header: the FSM state encodings (HDR0, HDR1, DATA, DONE, ERR) and the default CLKS_PER_BIT (50 MHz build), alongside the opcode defines.
- Sub-module `m_uart_rx` (parameter CLKS_PER_BIT):
  - Ports `w_clk`, `w_rst_n`, `w_rxd`, `r_byte`[7:0], `r_valid`, `r_ferr`.
  - Contains the synchroniser, bit counter and baud counter.
- The top level contains only the header/word FSM and the write-port registers.

## Test plan
- Header 0x0002, then bytes 24 00 00 20, 20 08 10 00 → `r_we` pulses twice: addr 0 data 0x24000020, then addr 1 data 0x20081000. `r_busy` falls with the second pulse and `r_done`=1.
- Header 0x0000 → no `r_we`; `r_busy`=0 and `r_done`=1 one cycle after the second header byte.
- Header 0x0001, then 2 data bytes with the stop bit of the 3rd byte forced to 0 → no `r_we`; `r_err`=1 and `r_busy` stays 1. A following valid byte is ignored.
- Header 0x1001 (4097) → `r_err`=1, no writes. Header 0x1000 with 16384 bytes → 4096 writes, last at addr 0xFFF, then DONE.
- Low pulse on `w_rxd` shorter than CLKS_PER_BIT/2 → no `byte_valid`; the next real byte decodes correctly.
- `w_rst_n` pulsed low after 2 data bytes of word 0 → outputs return to reset values. Re-sending header 0x0001 plus 4 bytes writes addr 0 with only the new data.
